// File: rtl/serial_add_sched_pkg.sv
// Shared types and defaults for the slice-serial adder with a two-requester front end.
// Holds the FSM state set, the default widths and the per-bit full-adder cell.
package serial_add_sched_pkg;

    localparam int SLICE_W_DEF = 8;
    localparam int WORD_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Returns {carry_out, sum} of one full-adder bit.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Request/response bundle between two requesters, one result consumer and serial_add_sched.
// The master side drives requests and rsp_ready; the slave side is the adder scheduler.
interface serial_add_sched_if #(
    parameter int WORD_W = serial_add_sched_pkg::WORD_W_DEF
);

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [WORD_W-1:0] req_a0;
    logic [WORD_W-1:0] req_b0;
    logic [WORD_W-1:0] req_a1;
    logic [WORD_W-1:0] req_b1;
    logic [1:0]        req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_sum;
    logic              rsp_cout;
    logic              rsp_id;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

endinterface

// File: rtl/add_slice.sv
// Combinational SLICE_W-bit ripple adder built from a chain of full-adder cells.
module add_slice
    import serial_add_sched_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    logic       carry;
    logic [1:0] fa;

    always_comb begin
        // NOTE: every variable written here gets a value first, so no path leaves it holding and no latch is inferred.
        sum_o = '0;
        carry = cin_i;
        fa    = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            fa       = full_add(a_i[i], b_i[i], carry);
            sum_o[i] = fa[0];
            carry    = fa[1];
        end
        cout_o = carry;
    end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler feeding one shared SLICE_W adder, LSB slice first, one slice per cycle.
// A WORD_W add takes WORD_W/SLICE_W BUSY cycles, then the result is held in DONE until taken.
module serial_add_sched
    import serial_add_sched_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic              TClk,
    input  logic              rst,
    serial_add_sched_if.slave bus
);

    localparam int            NSLICE = WORD_W / SLICE_W;
    localparam int            KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              id_q, id_d;
    logic              ptr_q, ptr_d;

    logic              gnt_id;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
    logic              sl_cout;

    assign sl_a = a_q[int'(k_q)*SLICE_W +: SLICE_W];
    assign sl_b = b_q[int'(k_q)*SLICE_W +: SLICE_W];

    add_slice #(.SLICE_W(SLICE_W)) u_add_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (carry_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout)
    );

    // A lone requester wins outright; under contention the pointer decides.
    assign gnt_id = (bus.req_valid == 2'b11) ? ptr_q : bus.req_valid[1];

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        a_d           = a_q;
        b_d           = b_q;
        sum_d         = sum_q;
        carry_d       = carry_q;
        id_d          = id_q;
        ptr_d         = ptr_q;
        bus.req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    bus.req_ready = rst ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);
                    a_d           = gnt_id ? bus.req_a1 : bus.req_a0;
                    b_d           = gnt_id ? bus.req_b1 : bus.req_b0;
                    carry_d       = bus.req_cin[gnt_id];
                    id_d          = gnt_id;
                    ptr_d         = ~gnt_id;
                    k_d           = '0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                sum_d[int'(k_q)*SLICE_W +: SLICE_W] = sl_sum;
                carry_d = sl_cout;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge TClk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = carry_q;
    assign bus.rsp_id    = id_q;

endmodule
